// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mult_pkg
//  Brief  : State encoding, width helpers and 8-bit CLA block function shared
//           by the shift-add multiplier.
//  Rev    : 1.0  initial release
// ============================================================================
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  function automatic bit width_legal(input int w);
    return (w >= 8) && ((w % 8) == 0);
  endfunction

  // Carries in sum-of-products lookahead form; returns {carry_out, sum}.
  function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y,
                                      input logic cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int j = 0; j < 8; j++) begin
      pp       = 1'b1;
      c[j+1]   = 1'b0;
      for (int k = j; k >= 0; k--) begin
        c[j+1] = c[j+1] | (pp & g[k]);
        pp     = pp & p[k];
      end
      c[j+1] = c[j+1] | (pp & cin);
    end
    return {c[8], p ^ c[7:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_add_stage.sv
`default_nettype none
// ============================================================================
//  Module : mult_add_stage
//  Brief  : WIDTH-bit adder built from chained 8-bit carry-lookahead blocks,
//           carry-in tied low.
//  Rev    : 1.0  initial release
// ============================================================================
module mult_add_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int NBLK = WIDTH / 8;

  logic [NBLK:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    logic [8:0] w_res;
    assign w_res            = cla8(a_i[8*i +: 8], b_i[8*i +: 8], w_c[i]);
    assign sum_o[8*i +: 8]  = w_res[7:0];
    assign w_c[i+1]         = w_res[8];
  end

  assign carry_o = w_c[NBLK];

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module : shift_add_multiplier
//  Brief  : Iterative shift-add multiplier, one partial product per clock,
//           start and valid/ack handshakes. Define MULT_SIGNED_EN for
//           two's-complement operands (adds a one-cycle sign-fix state).
//  Rev    : 1.0  initial release
// ============================================================================
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ack,
  output logic [2*WIDTH-1:0]   product
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("shift_add_multiplier: WIDTH must be a multiple of 8 and >= 8");
  end

`ifdef MULT_SIGNED_EN
  localparam state_e ST_AFTER_BUSY = ST_FIX;
`else
  localparam state_e ST_AFTER_BUSY = ST_DONE;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_a_lat;
  logic [WIDTH-1:0] w_b_lat;
  logic             w_sign;

`ifdef MULT_SIGNED_EN
  // Most-negative input negates to itself, which is its correct unsigned magnitude.
  assign w_a_lat = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_b_lat = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign w_sign  = a[WIDTH-1] ^ b[WIDTH-1];
`else
  assign w_a_lat = a;
  assign w_b_lat = b;
  assign w_sign  = 1'b0;
`endif

  assign w_addend = q_q[0] ? m_q : '0;

  mult_add_stage #(
    .WIDTH (WIDTH)
  ) u_add (
    .a_i     (acc_q),
    .b_i     (w_addend),
    .sum_o   (w_sum),
    .carry_o (w_carry)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = w_a_lat;
          q_d     = w_b_lat;
          acc_d   = '0;
          cnt_d   = '0;
          sign_d  = w_sign;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Add then shift {C,A,Q} right by one in a single step.
        {acc_d, q_d} = {w_carry, w_sum, q_q[WIDTH-1:1]};
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_AFTER_BUSY;
        end
      end
      ST_FIX: begin
        if (sign_q) begin
          {acc_d, q_d} = ~{acc_q, q_q} + 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign product   = {acc_q, q_q};

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module : tb_shift_add_multiplier
//  Brief  : Self-checking bench for shift_add_multiplier (WIDTH=16) against an
//           arithmetic reference model; honours MULT_SIGNED_EN.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_shift_add_multiplier;

  localparam int W = 16;
`ifdef MULT_SIGNED_EN
  localparam int EXP_LAT = W + 2;
`else
  localparam int EXP_LAT = W + 1;
`endif

  logic           clock;
  logic           reset_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           in_ready;
  logic           out_valid;
  logic           out_ack;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .product   (product)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint r;
`ifdef MULT_SIGNED_EN
    r = longint'($signed(x)) * longint'($signed(y));
`else
    r = longint'(x) * longint'(y);
`endif
    return r[2*W-1:0];
  endfunction

  // Called at a negedge: raise start with operands, then wait for out_valid.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [2*W-1:0] p, output int lat);
    start = 1'b1;
    a     = x;
    b     = y;
    lat   = 0;
    while (lat < 64) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      if (out_valid) break;
    end
    check("valid_seen", 64'(out_valid), 64'd1);
    p = product;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ack = 1'b0;
    check("ready_after_ack", 64'(in_ready), 64'd1);
  endtask

  task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [2*W-1:0] exp);
    logic [2*W-1:0] p;
    int             lat;
    issue(x, y, p, lat);
    check(tag, 64'(p), 64'(exp));
    check("latency", 64'(lat), 64'(EXP_LAT));
    ack();
  endtask

  initial begin
    logic [2*W-1:0] p;
    logic [2*W-1:0] hold;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    int             lat;

    reset_n = 1'b0;
    start   = 1'b0;
    out_ack = 1'b0;
    a       = '0;
    b       = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);

    op("3x5", 16'd3, 16'd5, 32'h0000_000F);
    op("ffff_sq", 16'hFFFF, 16'hFFFF, model(16'hFFFF, 16'hFFFF));

    // Backpressure: result must hold, start pulses ignored.
    x = 16'h1234;
    y = 16'h00AB;
    issue(x, y, hold, lat);
    check("bp_first", 64'(hold), 64'(model(x, y)));
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      a     = W'($urandom);
      b     = W'($urandom);
      @(posedge clock);
      @(negedge clock);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_product", 64'(product), 64'(hold));
    end
    start = 1'b0;
    ack();

    // Reset during BUSY step 7.
    start = 1'b1;
    a     = 16'hABCD;
    b     = 16'h7777;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (6) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check("midrst_ready", 64'(in_ready), 64'd1);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    op("7x9", 16'd7, 16'd9, 32'h0000_003F);

`ifdef MULT_SIGNED_EN
    op("neg3x5", 16'hFFFD, 16'd5, 32'hFFFF_FFF1);
`else
    op("fffdx5", 16'hFFFD, 16'd5, 32'h0004_FFF1);
`endif
    op("min_sq", 16'h8000, 16'h8000, 32'h4000_0000);

    // Back-to-back: ack and start together, only the ack acts.
    issue(16'd2, 16'd2, p, lat);
    check("b2b_first", 64'(p), 64'd4);
    out_ack = 1'b1;
    start   = 1'b1;
    a       = 16'h0010;
    b       = 16'h0010;
    @(posedge clock);
    @(negedge clock);
    out_ack = 1'b0;
    check("b2b_idle", 64'(in_ready), 64'd1);
    check("b2b_novalid", 64'(out_valid), 64'd0);
    issue(16'h0010, 16'h0010, p, lat);
    check("b2b_second", 64'(p), 64'h100);
    check("b2b_latency", 64'(lat), 64'(EXP_LAT));
    ack();

    for (int i = 0; i < 20; i++) begin
      x = W'($urandom);
      y = (i < 2) ? '0 : W'($urandom);
      op("random", x, y, model(x, y));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
